fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 17 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared front-end definitions for the RISC-V fetch path.
//   XLEN          : machine word width (instruction and address width)
//   NOP_INSTR     : canonical NOP (addi x0,x0,0) shown to decode when idle
//   fetch_state_t : fetch control state, RUN fetches, DRAIN discards
//                   responses still owed by memory after a redirect
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth and synchronous reset.
// Pointers carry one extra bit so full and empty are distinguished
// without a separate counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous empty (drops all entries), same effect as rst
//   push       : write push_data at the tail
//   push_data  : WIDTH-bit data to write
//   pop        : drop the head entry (caller guarantees non-empty)
//   head       : current head entry (valid when count != 0)
//   count      : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Users size their requests by credit, so a push into a full FIFO
  // means the credit accounting upstream is broken.
  always_ff @(posedge clk) begin
    if (!rst && !clear) assert (!(push && full));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues pc to instruction memory, tracks the
// in-order responses, buffers fetched words and hands them to decode.
// A redirect (flush) empties the buffer and, if memory still owes
// responses, enters DRAIN until every stale response has come back.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   pc / pc_advance                : fetch address in; step pulse out
//   flush                          : redirect, drops fetched and in-flight work
//   imem_req_valid/ready, imem_addr: request channel (addr = pc)
//   imem_rsp_valid, imem_rsp_data  : in-order response channel, never stalled
//   id_valid/ready, id_instr, id_pc: decode channel
//   state                          : debug view of the fetch FSM
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1; valid never depends on ready on the same channel.
module fetch_unit import riscv_pkg::*; #(
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output fetch_state_t    state
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state_next;
  logic              live;          // low for the first cycle after reset
  logic [CW-1:0]     outstanding;   // requests accepted, response not yet seen
  logic [CW-1:0]     occupancy;     // words waiting in the instruction buffer
  logic [CW-1:0]     out_next;
  logic [CW:0]       in_use;
  logic [XLEN-1:0]   rsp_pc;
  logic [2*XLEN-1:0] buf_head;
  logic              accept;
  logic              rsp_ok;
  logic              discard;
  logic              buf_push;
  logic              id_fire;

  // Every accepted request reserves a buffer slot until decode takes it,
  // so the buffer can never overflow.
  assign in_use   = {1'b0, outstanding} + {1'b0, occupancy};

  assign imem_addr      = pc;
  assign imem_req_valid = live && !rst && (state == RUN) && !flush
                          && (in_use < (CW+1)'(DEPTH));
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_advance     = accept;

  // A response with nothing outstanding is ignored entirely.
  assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
  assign discard  = flush || (state == DRAIN);
  assign buf_push = rsp_ok && !discard;
  assign id_fire  = id_valid && id_ready;
  assign out_next = outstanding + CW'(accept) - CW'(rsp_ok);

  assign id_valid = !rst && (occupancy != '0);
  assign id_instr = id_valid ? buf_head[XLEN-1:0]      : NOP_INSTR;
  assign id_pc    = id_valid ? buf_head[2*XLEN-1:XLEN] : '0;

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) addr_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (accept),
    .push_data (pc),
    .pop       (rsp_ok),
    .head      (rsp_pc),
    .count     (outstanding)
  );

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) ibuf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (buf_push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (id_fire),
    .head      (buf_head),
    .count     (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      live  <= 1'b0;
    end else begin
      state <= state_next;
      live  <= 1'b1;
    end
  end

  // Any response in the flush cycle implies outstanding != 0, so that
  // case is covered by the outstanding test. A flush during DRAIN keeps
  // us draining for at least one more cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush && (outstanding != '0)) state_next = DRAIN;
      DRAIN:   if (!flush && (out_next == '0))   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(imem_rsp_valid && (outstanding == '0)));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. Two instances (DEPTH=2 and DEPTH=4) share the
// stimulus; the one not under test is held in reset and its outputs are
// not observed. A reference model built from queues (pending memory
// requests, expected decode words, count of responses to drop) predicts
// every output each cycle.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  logic clk = 1'b0;
  logic rst, flush, imem_req_ready, imem_rsp_valid, id_ready, sel4;
  logic [31:0] pc, imem_rsp_data;
  logic rst2, rst4;

  logic a_adv, a_rv, a_iv, b_adv, b_rv, b_iv;
  logic [31:0] a_addr, a_ipc, a_ins, b_addr, b_ipc, b_ins;
  fetch_state_t a_st, b_st;

  logic pc_advance, imem_req_valid, id_valid;
  logic [31:0] imem_addr, id_pc, id_instr;
  fetch_state_t st;

  always #5 clk = ~clk;

  assign rst2 = rst || sel4;
  assign rst4 = rst || !sel4;

  fetch_unit #(.DEPTH(2)) dut2 (
    .clk(clk), .rst(rst2), .pc(pc), .pc_advance(a_adv), .flush(flush),
    .imem_req_valid(a_rv), .imem_req_ready(imem_req_ready), .imem_addr(a_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(a_iv), .id_ready(id_ready), .id_instr(a_ins), .id_pc(a_ipc),
    .state(a_st)
  );

  fetch_unit #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst4), .pc(pc), .pc_advance(b_adv), .flush(flush),
    .imem_req_valid(b_rv), .imem_req_ready(imem_req_ready), .imem_addr(b_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(b_iv), .id_ready(id_ready), .id_instr(b_ins), .id_pc(b_ipc),
    .state(b_st)
  );

  assign pc_advance     = sel4 ? b_adv  : a_adv;
  assign imem_req_valid = sel4 ? b_rv   : a_rv;
  assign imem_addr      = sel4 ? b_addr : a_addr;
  assign id_valid       = sel4 ? b_iv   : a_iv;
  assign id_pc          = sel4 ? b_ipc  : a_ipc;
  assign id_instr       = sel4 ? b_ins  : a_ins;
  assign st             = sel4 ? b_st   : a_st;

  // reference model and scoreboard
  logic [31:0] pend_q[$];   // accepted fetch addresses memory still owes
  logic [63:0] exp_q[$];    // {pc, instr} decode must see, in order
  int  depth, inflight, drop, mem_pct;
  bit  draining, boot;
  logic [31:0] salt;

  int checks = 0;
  int fails  = 0;

  // per-cycle observations and predictions
  logic [99:0] obs_vec, exp_vec;
  logic o_rv, o_adv, o_iv, last_hs;
  logic [31:0] o_addr, o_ipc, o_ins, last_hs_pc;

  function automatic string fmt(input logic [99:0] v);
    return $sformatf("drain=%b rv=%b adv=%b addr=%h iv=%b pc=%h instr=%h",
                     v[99], v[98], v[97], v[96:65], v[64], v[63:32], v[31:0]);
  endfunction

  // Driver: plays memory and the pc block for one clock, records what the
  // DUT shows and what the model predicts, then advances the model.
  task automatic cycle();
    logic [31:0] raddr;
    logic rv, exp_rv, exp_iv, hs, acc, adv;
    logic [31:0] exp_ipc, exp_ins;
    raddr = '0;
    rv = 1'b0;
    if (!rst && pend_q.size() > 0 && $urandom_range(1, 100) <= mem_pct) begin
      rv = 1'b1;
      raddr = pend_q.pop_front();
    end
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? (raddr ^ salt) : $urandom();
    #1;
    exp_rv  = !rst && !boot && !draining && !flush && (inflight + exp_q.size() < depth);
    exp_iv  = !rst && exp_q.size() > 0;
    exp_ipc = exp_iv ? exp_q[0][63:32] : 32'h0;
    exp_ins = exp_iv ? exp_q[0][31:0]  : NOP_WORD;
    exp_vec = {(!rst && draining), exp_rv, (exp_rv && imem_req_ready), pc, exp_iv, exp_ipc, exp_ins};
    o_rv = imem_req_valid; o_adv = pc_advance; o_addr = imem_addr;
    o_iv = id_valid; o_ipc = id_pc; o_ins = id_instr;
    obs_vec = {(!rst && st == DRAIN), o_rv, o_adv, o_addr, o_iv, o_ipc, o_ins};
    hs  = id_valid && id_ready;
    acc = imem_req_valid && imem_req_ready;
    adv = pc_advance;
    last_hs = hs;
    last_hs_pc = id_pc;
    if (rst) begin
      exp_q.delete(); pend_q.delete();
      inflight = 0; drop = 0; draining = 1'b0; boot = 1'b1;
    end else begin
      boot = 1'b0;
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      if (flush) begin
        exp_q.delete();
        drop = inflight;
        if (inflight > 0) draining = 1'b1;
      end
      if (rv) begin
        inflight--;
        if (drop > 0) drop--;
        else exp_q.push_back({raddr, raddr ^ salt});
      end
      if (draining && !flush && drop == 0) draining = 1'b0;
      if (acc) begin
        pend_q.push_back(imem_addr);
        inflight++;
      end
    end
    @(negedge clk);
    if (adv && !rst) pc = pc + 32'd4;
  endtask

  task automatic do_reset(input bit s);
    sel4 = s;
    depth = s ? 4 : 2;
    rst = 1'b1;
    flush = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel4 = 1'b0; depth = 2; rst = 1'b1; flush = 1'b0; pc = 32'h0;
    id_ready = 1'b1; imem_req_ready = 1'b1; mem_pct = 100;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (o_rv !== 1'b0 || o_iv !== 1'b0 || o_adv !== 1'b0) begin
        fails++;
        $display("FAIL rst_quiet cyc%0d got rv=%b iv=%b adv=%b want 0 0 0", k, o_rv, o_iv, o_adv);
      end
      checks++;
      if (o_ins !== NOP_WORD || o_ipc !== 32'h0) begin
        fails++;
        $display("FAIL rst_id cyc%0d got instr=%h pc=%h want %h 0", k, o_ins, o_ipc, NOP_WORD);
      end
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (o_rv !== 1'b0 || obs_vec !== exp_vec) begin
      fails++;
      $display("FAIL rst_first_cycle got %s want %s", fmt(obs_vec), fmt(exp_vec));
    end
    cycle();
    checks++;
    if (o_rv !== 1'b1 || o_addr !== 32'h0 || o_adv !== 1'b1) begin
      fails++;
      $display("FAIL rst_first_req got rv=%b addr=%h adv=%b want 1 0 1", o_rv, o_addr, o_adv);
    end
  endtask

  task automatic test_streaming();
    pc = 32'h0; id_ready = 1'b1; imem_req_ready = 1'b1; mem_pct = 100;
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL stream_model cyc%0d got %s want %s", k, fmt(obs_vec), fmt(exp_vec));
      end
      if (k >= 1) begin
        checks++;
        if (o_adv !== 1'b1) begin
          fails++;
          $display("FAIL stream_adv cyc%0d got %b want 1", k, o_adv);
        end
      end
      if (k >= 3 && k <= 5) begin
        logic [31:0] want_pc;
        want_pc = 32'((k - 3) * 4);
        checks++;
        if (o_iv !== 1'b1 || o_ipc !== want_pc || o_ins !== (want_pc ^ salt)) begin
          fails++;
          $display("FAIL stream_id cyc%0d got iv=%b pc=%h instr=%h want 1 %h %h",
                   k, o_iv, o_ipc, o_ins, want_pc, want_pc ^ salt);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n_acc;
    logic [31:0] nxt;
    pc = 32'h0; id_ready = 1'b0; imem_req_ready = 1'b1; mem_pct = 100;
    do_reset(1'b0);
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (o_rv && imem_req_ready) n_acc++;
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL bp_model cyc%0d got %s want %s", k, fmt(obs_vec), fmt(exp_vec));
      end
    end
    checks++;
    if (n_acc !== 2 || o_rv !== 1'b0) begin
      fails++;
      $display("FAIL bp_accepts got %0d accepts rv=%b want 2 accepts rv=0", n_acc, o_rv);
    end
    id_ready = 1'b1;
    nxt = 32'h0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL bp_resume cyc%0d got %s want %s", k, fmt(obs_vec), fmt(exp_vec));
      end
      if (last_hs) begin
        checks++;
        if (last_hs_pc !== nxt) begin
          fails++;
          $display("FAIL bp_order got pc=%h want %h", last_hs_pc, nxt);
        end
        nxt = nxt + 32'd4;
      end
    end
    checks++;
    if (nxt < 32'd20) begin
      fails++;
      $display("FAIL bp_progress got %0d delivered want >= 5", nxt / 4);
    end
  endtask

  task automatic test_flush_inflight();
    int n_acc;
    bit seen;
    pc = 32'h0; id_ready = 1'b0; imem_req_ready = 1'b1; mem_pct = 0;
    do_reset(1'b0);
    n_acc = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (o_rv && imem_req_ready) n_acc++;
    end
    checks++;
    if (n_acc !== 2) begin
      fails++;
      $display("FAIL fl_setup got %0d accepts want 2", n_acc);
    end
    flush = 1'b1; pc = 32'h20;
    cycle();
    checks++;
    if (o_rv !== 1'b0 || obs_vec !== exp_vec) begin
      fails++;
      $display("FAIL fl_cycle got %s want %s", fmt(obs_vec), fmt(exp_vec));
    end
    flush = 1'b0; mem_pct = 100; id_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL fl_model cyc%0d got %s want %s", k, fmt(obs_vec), fmt(exp_vec));
      end
      if (last_hs) begin
        seen = 1'b1;
        checks++;
        if (last_hs_pc !== 32'h20) begin
          fails++;
          $display("FAIL fl_first_pc got %h want 00000020", last_hs_pc);
        end
      end
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL fl_timeout got no decode handshake want pc 00000020 within 20 cycles");
    end
  endtask

  task automatic test_simultaneous();
    bit ready_pt, seen;
    pc = 32'h0; id_ready = 1'b1; imem_req_ready = 1'b1; mem_pct = 100;
    do_reset(1'b0);
    ready_pt = 1'b0;
    for (int k = 0; k < 10 && !ready_pt; k++) begin
      if (pend_q.size() > 0 && exp_q.size() > 0) ready_pt = 1'b1;
      else cycle();
    end
    checks++;
    if (!ready_pt) begin
      fails++;
      $display("FAIL sim_setup got no cycle with both response and decode word want one");
    end
    flush = 1'b1; pc = 32'h40;
    cycle();
    checks++;
    if (obs_vec !== exp_vec) begin
      fails++;
      $display("FAIL sim_flush_cycle got %s want %s", fmt(obs_vec), fmt(exp_vec));
    end
    flush = 1'b0;
    cycle();
    checks++;
    if (o_iv !== 1'b0 || obs_vec !== exp_vec) begin
      fails++;
      $display("FAIL sim_no_hs got %s want %s", fmt(obs_vec), fmt(exp_vec));
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      if (last_hs) begin
        seen = 1'b1;
        checks++;
        if (last_hs_pc !== 32'h40) begin
          fails++;
          $display("FAIL sim_first_pc got %h want 00000040", last_hs_pc);
        end
      end
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL sim_timeout got no decode handshake want pc 00000040 within 20 cycles");
    end
  endtask

  task automatic test_mem_stall();
    pc = 32'h10; id_ready = 1'b1; imem_req_ready = 1'b0; mem_pct = 100;
    do_reset(1'b0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (o_adv !== 1'b0 || o_addr !== 32'h10 || obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL stall cyc%0d got %s want %s", k, fmt(obs_vec), fmt(exp_vec));
      end
    end
    imem_req_ready = 1'b1;
    cycle();
    checks++;
    if (o_adv !== 1'b1 || o_addr !== 32'h10) begin
      fails++;
      $display("FAIL stall_accept got adv=%b addr=%h want 1 00000010", o_adv, o_addr);
    end
    imem_req_ready = 1'b0;
    cycle();
    checks++;
    if (o_adv !== 1'b0 || o_addr !== 32'h14) begin
      fails++;
      $display("FAIL stall_single got adv=%b addr=%h want 0 00000014", o_adv, o_addr);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      pc = $urandom() & 32'h0000fffc;
      mem_pct = 100;
      do_reset(r[0]);
      for (int k = 0; k < 300; k++) begin
        rst = (k >= 150 && k < 152);
        flush = ($urandom_range(0, 99) < 6);
        if (flush) pc = $urandom() & 32'h0000fffc;
        id_ready = ($urandom_range(0, 99) < 70);
        imem_req_ready = ($urandom_range(0, 99) < 75);
        mem_pct = $urandom_range(20, 100);
        cycle();
        checks++;
        if (obs_vec !== exp_vec) begin
          fails++;
          $display("FAIL rand d%0d cyc%0d got %s want %s", depth, k, fmt(obs_vec), fmt(exp_vec));
        end
      end
      rst = 1'b0;
      flush = 1'b0;
    end
  endtask

  initial begin
    salt = $urandom() | 32'h00010000;
    rst = 1'b1; flush = 1'b0; sel4 = 1'b0; pc = '0; id_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    depth = 2; inflight = 0; drop = 0; draining = 1'b0; boot = 1'b1; mem_pct = 100;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_inflight();
    test_simultaneous();
    test_mem_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
